proc_core: RTL and testbench

PROC_CORE -- requirements
Module: proc_core

---
 rtl/proc_pkg.sv | 30 +++
 rtl/proc_regfile.sv | 31 +++
 rtl/proc_core.sv | 175 +++++++++++++++++
 tb/tb_proc_core.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types and constants for the accumulator processor core.
package proc_pkg;

   localparam int RETIRED_W = 16;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_LDI  = 3'd2,
      OP_MOV  = 3'd3,
      OP_LW   = 3'd4,
      OP_SW   = 3'd5,
      OP_BEQZ = 3'd6,
      OP_HALT = 3'd7
   } opcode_e;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_HALT   = 3'd4
   } state_e;

   // True when v is a positive power of two; used for parameter legality.
   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/proc_regfile.sv
// Register file: REG_DEPTH x DATA_W, asynchronous read, synchronous write,
// synchronous clear on rst.
module proc_regfile #(
   parameter int DATA_W    = 8,
   parameter int REG_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         we,
   input  logic [$clog2(REG_DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [$clog2(REG_DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]            rdata
);

   logic [DATA_W-1:0] regs_r [REG_DEPTH];

   // Clear all entries on reset, otherwise write one entry when enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_DEPTH; i++) begin
            regs_r[i] <= '0;
         end
      end else if (we) begin
         regs_r[waddr] <= wdata;
      end
   end

   assign rdata = regs_r[raddr];

endmodule

// File: rtl/proc_core.sv
// Multi-cycle accumulator processor: FETCH -> DECODE -> EXEC (-> MEM for LW),
// single shared memory port for instructions and data.
module proc_core
   import proc_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int REG_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [DATA_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   output logic                 mem_we,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic [DATA_W-1:0]    pc_out,
   output logic [DATA_W-1:0]    acc_out,
   output logic                 halted,
   output logic [RETIRED_W-1:0] retired
);

   localparam int IDX_W = $clog2(REG_DEPTH);
   localparam int IMM_W = DATA_W - 3;

   localparam bit PARAMS_OK = (DATA_W >= 6) && (DATA_W <= 16) &&
                              (REG_DEPTH >= 2) && is_pow2(REG_DEPTH) &&
                              (REG_DEPTH <= (1 << (DATA_W - 3)));

   generate
      if (!PARAMS_OK) begin : g_param_check
         $error("proc_core: illegal DATA_W/REG_DEPTH combination");
      end
   endgenerate

   state_e                 state_r, state_s;
   logic [DATA_W-1:0]      pc_r, acc_r, ir_r;
   logic [RETIRED_W-1:0]   retired_r;
   logic                   halted_r;

   opcode_e                opcode_s;
   logic [IMM_W-1:0]       imm_s;
   logic [IDX_W-1:0]       idx_s;
   logic [DATA_W-1:0]      sext_s;
   logic [DATA_W-1:0]      rf_rdata_s;
   logic                   rf_we_s;
   logic [DATA_W-1:0]      rf_wdata_s;
   logic [DATA_W-1:0]      mem_addr_s, mem_wdata_s;
   logic                   mem_we_s;
   logic                   retire_s;

   assign opcode_s = opcode_e'(ir_r[DATA_W-1 -: 3]);
   assign imm_s    = ir_r[IMM_W-1:0];
   assign idx_s    = imm_s[IDX_W-1:0];
   assign sext_s   = {{3{imm_s[IMM_W-1]}}, imm_s};

   proc_regfile #(
      .DATA_W    (DATA_W),
      .REG_DEPTH (REG_DEPTH)
   ) u_regfile (
      .clk   (clk),
      .rst   (rst),
      .we    (rf_we_s),
      .waddr (idx_s),
      .wdata (rf_wdata_s),
      .raddr (idx_s),
      .rdata (rf_rdata_s)
   );

   // Next-state, memory port, register-file write and retire decode.
   always_comb begin
      state_s     = state_r;
      mem_addr_s  = pc_r;
      mem_wdata_s = '0;
      mem_we_s    = 1'b0;
      rf_we_s     = 1'b0;
      rf_wdata_s  = '0;
      retire_s    = 1'b0;
      case (state_r)
         ST_FETCH:  state_s = ST_DECODE;
         ST_DECODE: state_s = ST_EXEC;
         ST_EXEC: begin
            case (opcode_s)
               OP_MOV: begin
                  rf_we_s    = 1'b1;
                  rf_wdata_s = acc_r;
                  retire_s   = 1'b1;
                  state_s    = ST_FETCH;
               end
               OP_LW: begin
                  mem_addr_s = acc_r;
                  state_s    = ST_MEM;
               end
               OP_SW: begin
                  // A reset arriving on this edge must not leave a stray store.
                  mem_addr_s  = acc_r;
                  mem_wdata_s = rf_rdata_s;
                  mem_we_s    = !rst;
                  retire_s    = 1'b1;
                  state_s     = ST_FETCH;
               end
               OP_HALT: begin
                  retire_s = 1'b1;
                  state_s  = ST_HALT;
               end
               default: begin
                  retire_s = 1'b1;
                  state_s  = ST_FETCH;
               end
            endcase
         end
         ST_MEM: begin
            mem_addr_s = acc_r;
            rf_we_s    = 1'b1;
            rf_wdata_s = mem_rdata;
            retire_s   = 1'b1;
            state_s    = ST_FETCH;
         end
         ST_HALT: state_s = ST_HALT;
         default: state_s = ST_FETCH;
      endcase
   end

   // FSM state register and halted flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_FETCH;
         halted_r <= 1'b0;
      end else begin
         state_r  <= state_s;
         halted_r <= (state_s == ST_HALT);
      end
   end

   // Instruction register, PC and accumulator updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         ir_r  <= '0;
         pc_r  <= '0;
         acc_r <= '0;
      end else if (state_r == ST_DECODE) begin
         ir_r <= mem_rdata;
         pc_r <= pc_r + DATA_W'(1);
      end else if (state_r == ST_EXEC) begin
         case (opcode_s)
            OP_ADD:  acc_r <= acc_r + rf_rdata_s;
            OP_SUB:  acc_r <= acc_r - rf_rdata_s;
            OP_LDI:  acc_r <= sext_s;
            OP_BEQZ: begin
               // Taken branch replaces the increment done in DECODE.
               if (acc_r == '0) begin
                  pc_r <= rf_rdata_s;
               end
            end
            default: ;
         endcase
      end
   end

   // Saturating count of completed instructions.
   always_ff @(posedge clk) begin
      if (rst) begin
         retired_r <= '0;
      end else if (retire_s && (retired_r != {RETIRED_W{1'b1}})) begin
         retired_r <= retired_r + RETIRED_W'(1);
      end
   end

   assign mem_addr  = mem_addr_s;
   assign mem_wdata = mem_wdata_s;
   assign mem_we    = mem_we_s;
   assign pc_out    = pc_r;
   assign acc_out   = acc_r;
   assign halted    = halted_r;
   assign retired   = retired_r;

endmodule

// File: tb/tb_proc_core.sv
// Self-checking bench for proc_core: directed scenarios plus random programs
// checked against an instruction-level reference model.
module tb_proc_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---- 8-bit instance ----
   logic        rst = 1'b1, load = 1'b1;
   logic [7:0]  mem_addr, mem_wdata, mem_rdata, pc_out, acc_out;
   logic        mem_we, halted;
   logic [15:0] retired;
   logic [7:0]  mem  [256];
   logic [7:0]  prog [256];

   proc_core #(.DATA_W(8), .REG_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata), .pc_out(pc_out),
      .acc_out(acc_out), .halted(halted), .retired(retired)
   );

   // Synchronous memory: one-cycle read latency, program load during reset.
   always @(posedge clk) begin
      if (load) mem <= prog;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   // ---- 12-bit instance ----
   logic        rst2 = 1'b1, load2 = 1'b1;
   logic [11:0] m2_addr, m2_wdata, m2_rdata, pc2, acc2;
   logic        m2_we, halted2;
   logic [15:0] retired2;
   logic [11:0] mem2  [64];
   logic [11:0] prog2 [64];

   proc_core #(.DATA_W(12), .REG_DEPTH(8)) dut2 (
      .clk(clk), .rst(rst2), .mem_addr(m2_addr), .mem_wdata(m2_wdata),
      .mem_we(m2_we), .mem_rdata(m2_rdata), .pc_out(pc2),
      .acc_out(acc2), .halted(halted2), .retired(retired2)
   );

   // Memory for the wide instance (only low address bits used).
   always @(posedge clk) begin
      if (load2) mem2 <= prog2;
      else if (m2_we) mem2[m2_addr[5:0]] <= m2_wdata;
      m2_rdata <= mem2[m2_addr[5:0]];
   end

   int n_cmp = 0;
   int n_err = 0;

   // ---- reference model (ISA level) ----
   int rm_mem [256];
   int rm_r [4];
   int rm_pc, rm_acc, rm_ret;
   bit rm_halt;

   task automatic model_reset();
      for (int i = 0; i < 256; i++) rm_mem[i] = int'(prog[i]);
      for (int i = 0; i < 4; i++) rm_r[i] = 0;
      rm_pc = 0; rm_acc = 0; rm_ret = 0; rm_halt = 0;
   endtask

   task automatic model_step(output int lat);
      int ins, op, imm, idx;
      if (rm_halt) begin
         lat = 1;
         return;
      end
      ins = rm_mem[rm_pc];
      op  = ins / 32;
      imm = ins % 32;
      idx = imm % 4;
      rm_pc = (rm_pc + 1) % 256;
      lat = 3;
      case (op)
         0: rm_acc = (rm_acc + rm_r[idx]) % 256;
         1: rm_acc = (rm_acc - rm_r[idx] + 256) % 256;
         2: rm_acc = (imm < 16) ? imm : imm + 224;
         3: rm_r[idx] = rm_acc;
         4: begin rm_r[idx] = rm_mem[rm_acc]; lat = 4; end
         5: rm_mem[rm_acc] = rm_r[idx];
         6: if (rm_acc == 0) rm_pc = rm_r[idx];
         default: rm_halt = 1;
      endcase
      if (rm_ret < 65535) rm_ret++;
   endtask

   // ---- helpers ----
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; load = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0; load = 1'b0;
   endtask

   task automatic fill_prog(input logic [7:0] v);
      for (int i = 0; i < 256; i++) prog[i] = v;
   endtask

   // ---- tests ----
   task automatic test_reset();
      fill_prog(8'h45);          // LDI 5 everywhere
      prog[1] = 8'h61;           // MOV R1
      do_reset();
      tick(7);
      do_reset();
      n_cmp++; if (pc_out !== 8'h00) begin n_err++; $display("FAIL reset_pc: got %h want 00", pc_out); end
      n_cmp++; if (acc_out !== 8'h00) begin n_err++; $display("FAIL reset_acc: got %h want 00", acc_out); end
      n_cmp++; if (retired !== 16'h0) begin n_err++; $display("FAIL reset_retired: got %h want 0", retired); end
      n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
      n_cmp++; if (mem_we !== 1'b0 || mem_addr !== 8'h00) begin
         n_err++; $display("FAIL reset_mem: we=%b addr=%h want 0/00", mem_we, mem_addr);
      end
   endtask

   task automatic test_basic_program();
      fill_prog(8'hE0);
      prog[0] = 8'h45; prog[1] = 8'h61; prog[2] = 8'h43; prog[3] = 8'h01; prog[4] = 8'hE0;
      do_reset();
      tick(14);
      n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL prog_halt_early: got %b want 0", halted); end
      tick(1);
      n_cmp++; if (acc_out !== 8'h08) begin n_err++; $display("FAIL prog_acc: got %h want 08", acc_out); end
      n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL prog_halted: got %b want 1", halted); end
      n_cmp++; if (retired !== 16'd5) begin n_err++; $display("FAIL prog_retired: got %0d want 5", retired); end
      tick(10);
      n_cmp++; if (pc_out !== 8'h05 || acc_out !== 8'h08 || retired !== 16'd5 || halted !== 1'b1) begin
         n_err++; $display("FAIL halt_sticky: pc=%h acc=%h ret=%0d h=%b want 05/08/5/1", pc_out, acc_out, retired, halted);
      end
      do_reset();
      n_cmp++; if (halted !== 1'b0 || pc_out !== 8'h00) begin
         n_err++; $display("FAIL rst_over_halt: h=%b pc=%h want 0/00", halted, pc_out);
      end
   endtask

   task automatic test_store();
      fill_prog(8'hE0);
      prog[0] = 8'h5F; prog[1] = 8'h60; prog[2] = 8'h40; prog[3] = 8'hA0;
      do_reset();
      tick(10);
      n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL sw_we_decode: got %b want 0", mem_we); end
      tick(1);
      n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 8'hFF) begin
         n_err++; $display("FAIL sw_exec: we=%b addr=%h wdata=%h want 1/00/FF", mem_we, mem_addr, mem_wdata);
      end
      tick(1);
      n_cmp++; if (mem_we !== 1'b0 || mem[0] !== 8'hFF) begin
         n_err++; $display("FAIL sw_after: we=%b mem0=%h want 0/FF", mem_we, mem[0]);
      end
   endtask

   task automatic test_load_wrap();
      fill_prog(8'hE0);
      prog[0] = 8'h45; prog[1] = 8'h82; prog[2] = 8'h44; prog[3] = 8'h80;
      prog[4] = 8'h7F; prog[5] = 8'h7D; prog[6] = 8'h44; prog[7] = 8'h00;
      prog[8] = 8'h02; prog[9] = 8'hE0;
      do_reset();
      tick(5);
      n_cmp++; if (mem_addr !== 8'h05) begin n_err++; $display("FAIL lw_addr: got %h want 05", mem_addr); end
      tick(1);
      n_cmp++; if (retired !== 16'd1) begin n_err++; $display("FAIL lw_in_mem: retired %0d want 1", retired); end
      tick(1);
      n_cmp++; if (retired !== 16'd2) begin n_err++; $display("FAIL lw_done: retired %0d want 2", retired); end
      tick(19);
      n_cmp++; if (acc_out !== 8'h83) begin n_err++; $display("FAIL lw_add: got %h want 83", acc_out); end
      tick(3);
      n_cmp++; if (acc_out !== 8'h00) begin n_err++; $display("FAIL add_wrap: got %h want 00", acc_out); end
   endtask

   task automatic test_branch();
      fill_prog(8'hE0);
      prog[0] = 8'h46; prog[1] = 8'h62; prog[2] = 8'h40; prog[3] = 8'hC2;
      do_reset();
      tick(12);
      n_cmp++; if (mem_addr !== 8'h06 || pc_out !== 8'h06) begin
         n_err++; $display("FAIL beqz_taken: addr=%h pc=%h want 06", mem_addr, pc_out);
      end
      prog[2] = 8'h41;
      do_reset();
      tick(12);
      n_cmp++; if (mem_addr !== 8'h04 || pc_out !== 8'h04) begin
         n_err++; $display("FAIL beqz_not_taken: addr=%h pc=%h want 04", mem_addr, pc_out);
      end
   endtask

   task automatic test_reset_in_sw();
      fill_prog(8'hE0);
      prog[0] = 8'h5F; prog[1] = 8'h60; prog[2] = 8'h40; prog[3] = 8'hA0;
      do_reset();
      tick(11);
      rst = 1'b1;
      #1;
      n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_sw_we: got %b want 0", mem_we); end
      tick(1);
      rst = 1'b0;
      n_cmp++; if (pc_out !== 8'h00 || acc_out !== 8'h00 || mem_we !== 1'b0) begin
         n_err++; $display("FAIL rst_sw_state: pc=%h acc=%h we=%b want 00/00/0", pc_out, acc_out, mem_we);
      end
      n_cmp++; if (mem[0] !== 8'h5F) begin n_err++; $display("FAIL rst_sw_nowrite: mem0=%h want 5F", mem[0]); end
   endtask

   task automatic test_wide();
      for (int i = 0; i < 64; i++) prog2[i] = 12'hE00;
      prog2[0] = 12'h405; prog2[1] = 12'h607; prog2[2] = 12'h403; prog2[3] = 12'h007;
      rst2 = 1'b1; load2 = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst2 = 1'b0; load2 = 1'b0;
      tick(15);
      n_cmp++; if (acc2 !== 12'h008 || halted2 !== 1'b1 || retired2 !== 16'd5) begin
         n_err++; $display("FAIL wide_prog: acc=%h h=%b ret=%0d want 008/1/5", acc2, halted2, retired2);
      end
   endtask

   task automatic test_random();
      int lat, diff;
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < 256; i++) begin
            logic [2:0] op;
            op = ($urandom_range(0, 31) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            prog[i] = {op, 5'($urandom_range(0, 31))};
         end
         model_reset();
         do_reset();
         for (int k = 0; k < 50; k++) begin
            model_step(lat);
            tick(lat);
            n_cmp++; if (pc_out !== 8'(rm_pc) || acc_out !== 8'(rm_acc) ||
                         retired !== 16'(rm_ret) || halted !== rm_halt) begin
               n_err++;
               $display("FAIL rand_step it%0d k%0d: pc=%h acc=%h ret=%0d h=%b want %h/%h/%0d/%b",
                        it, k, pc_out, acc_out, retired, halted, 8'(rm_pc), 8'(rm_acc), rm_ret, rm_halt);
            end
         end
         diff = 0;
         for (int i = 0; i < 256; i++) if (mem[i] !== 8'(rm_mem[i])) diff++;
         n_cmp++; if (diff != 0) begin n_err++; $display("FAIL rand_mem it%0d: %0d differing bytes want 0", it, diff); end
      end
   endtask

   initial begin
      test_reset();
      test_basic_program();
      test_store();
      test_load_wrap();
      test_branch();
      test_reset_in_sw();
      test_wide();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
